dmem_access_seq: RTL and testbench

- Multi-cycle data-memory access sequencer between the decoder outputs (mem_rd, mem_wr, mem_ctrl) and a request/grant data bus.
- Accepts one load/store per instruction. Generates byte enables and store-data lane replication, extracts and extends load data, and holds the pipeline stalled until the access completes.
- Reports misaligned, illegal-encoding and timeout faults.

---
 rtl/dmem_access_seq.sv | 192 +++++++++++++++++++
 tb/tb_dmem_access_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_seq.sv
// Load/store sequencer between the decoder and a request/grant data bus.
// Formats byte enables, store lanes and load results; stalls the pipe until the access ends.
module dmem_access_seq #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [2:0]      mem_ctrl,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam int unsigned CNT_LAST = TIMEOUT - 1;
  localparam logic [1:0]  SZ_BYTE  = 2'd0;
  localparam logic [1:0]  SZ_HALF  = 2'd1;
  localparam logic [1:0]  SZ_WORD  = 2'd2;

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [2:0]      ctrl_q;
  logic            we_q;
  logic            timed_out;

  logic            start_c, enc_err_c, mis_c, go_c, last_c, timeout_c;
  logic [1:0]      sz_in_c, sz_q_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wlane_c, shifted_c, fmt_c;

  function automatic logic [1:0] size_of(input logic [2:0] c);
    case (c)
      3'b000, 3'b011, 3'b101: size_of = SZ_BYTE;
      3'b001, 3'b100, 3'b110: size_of = SZ_HALF;
      default:                size_of = SZ_WORD;
    endcase
  endfunction

  // Start-cycle qualification: encoding first, then alignment
  always_comb begin
    sz_in_c   = size_of(mem_ctrl);
    start_c   = (state == S_IDLE) && (mem_rd || mem_wr);
    enc_err_c = start_c && (mem_wr ? (mem_ctrl < 3'd5) : (mem_ctrl > 3'd4));
    mis_c     = start_c && !enc_err_c &&
                (((sz_in_c == SZ_HALF) && addr[0]) ||
                 ((sz_in_c == SZ_WORD) && (addr[1:0] != 2'b00)));
    go_c      = start_c && !enc_err_c && !mis_c;
    last_c    = (cnt == TO_W'(CNT_LAST));
    // A load granted on the last budgeted cycle still counts as incomplete
    timeout_c = last_c &&
                (((state == S_REQ) && !(bus_gnt && we_q)) ||
                 ((state == S_WAIT) && !bus_rvalid));
  end

  // Lane steering from the latched access
  always_comb begin
    sz_q_c = size_of(ctrl_q);
    case (sz_q_c)
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wlane_c = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be_c    = 4'b0011 << addr_q[1:0];
        wlane_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wlane_c = wdata_q;
      end
    endcase
    shifted_c = bus_rdata >> {addr_q[1:0], 3'b000};
    case (ctrl_q)
      3'b000:  fmt_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b011:  fmt_c = {24'd0, shifted_c[7:0]};
      3'b001:  fmt_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  fmt_c = {16'd0, shifted_c[15:0]};
      default: fmt_c = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (go_c) state_nxt = S_REQ;
      S_REQ: begin
        if (bus_gnt && we_q)  state_nxt = S_DONE;
        else if (last_c)      state_nxt = S_DONE;
        else if (bus_gnt)     state_nxt = S_WAIT;
      end
      S_WAIT: if (bus_rvalid || last_c) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Access latches, timeout counter and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ctrl_q    <= '0;
      we_q      <= 1'b0;
      timed_out <= 1'b0;
      rdata     <= '0;
    end else begin
      if (go_c) begin
        cnt       <= '0;
        addr_q    <= addr;
        wdata_q   <= wdata;
        ctrl_q    <= mem_ctrl;
        we_q      <= mem_wr;
        timed_out <= 1'b0;
      end else if ((state == S_REQ) || (state == S_WAIT)) begin
        cnt <= cnt + TO_W'(1);
      end
      if (timeout_c) begin
        timed_out <= 1'b1;
        rdata     <= '0;
      end else if ((state == S_WAIT) && bus_rvalid) begin
        rdata <= fmt_c;
      end
    end
  end

  always_comb begin
    stall       = 1'b0;
    rdata_valid = 1'b0;
    fault       = 1'b0;
    fault_cause = 2'b00;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_be      = 4'b0000;
    bus_wdata   = '0;
    case (state)
      S_IDLE: begin
        stall = go_c;
        if (enc_err_c) begin
          fault       = 1'b1;
          fault_cause = 2'b10;
        end else if (mis_c) begin
          fault       = 1'b1;
          fault_cause = 2'b01;
        end
      end
      S_REQ: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[XLEN-1:2], 2'b00};
        bus_be    = be_c;
        bus_wdata = we_q ? wlane_c : '0;
      end
      S_WAIT: stall = 1'b1;
      S_DONE: begin
        if (timed_out) begin
          fault       = 1'b1;
          fault_cause = 2'b11;
        end else begin
          rdata_valid = !we_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_seq.sv
// Directed bench for dmem_access_seq: loads, stores, faults, timeout and reset abort.
module tb_dmem_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd, mem_wr;
  logic [2:0]  mem_ctrl;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, fault;
  logic [1:0]  fault_cause;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  dmem_access_seq #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ctrl(mem_ctrl), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
    .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle-cycle snapshot: no bus activity, no stall, no fault
  task automatic chk_quiet(input string tag);
    chk({tag, ".bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, ".stall"},   32'(stall),   32'd0);
    chk({tag, ".fault"},   32'(fault),   32'd0);
  endtask

  // Load with grant in the first REQ cycle and read data one cycle later
  task automatic do_load(input string tag, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] baddr, input logic [31:0] exp);
    @(negedge clk); mem_rd = 1'b1; mem_ctrl = c; addr = a;
    #1 chk({tag, ".start_stall"}, 32'(stall), 32'd1);
    @(negedge clk); mem_rd = 1'b0; bus_gnt = 1'b1;
    #1 chk({tag, ".bus_req"},  32'(bus_req), 32'd1);
    chk({tag, ".bus_be"},   32'(bus_be),  32'(be));
    chk({tag, ".bus_addr"}, bus_addr,     baddr);
    chk({tag, ".bus_we"},   32'(bus_we),  32'd0);
    @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = d;
    #1 chk({tag, ".wait_req"},   32'(bus_req), 32'd0);
    chk({tag, ".wait_stall"}, 32'(stall),   32'd1);
    @(negedge clk); bus_rvalid = 1'b0; bus_rdata = 32'h5A5A_5A5A;
    #1 chk({tag, ".rdata"},       rdata,              exp);
    chk({tag, ".rdata_valid"}, 32'(rdata_valid), 32'd1);
    chk({tag, ".done_stall"},  32'(stall),       32'd0);
    chk({tag, ".done_fault"},  32'(fault),       32'd0);
  endtask

  initial begin
    rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_ctrl = 3'b000;
    addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #2;
    chk_quiet("rst");
    chk("rst.rdata",    rdata,             32'd0);
    chk("rst.bus_addr", bus_addr,          32'd0);
    chk("rst.cause",    32'(fault_cause),  32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // LW 0x100: grant in the second REQ cycle, read data two cycles after grant
    @(negedge clk); mem_rd = 1'b1; mem_ctrl = 3'b010; addr = 32'h100;
    #1 chk("lw.start_stall", 32'(stall),   32'd1);
    chk("lw.start_req",   32'(bus_req), 32'd0);
    @(negedge clk); mem_rd = 1'b0;
    #1 chk("lw.req1",   32'(bus_req), 32'd1);
    chk("lw.be",     32'(bus_be),  32'hF);
    chk("lw.addr",   bus_addr,     32'h100);
    @(negedge clk); bus_gnt = 1'b1;
    #1 chk("lw.req2",   32'(bus_req), 32'd1);
    chk("lw.stall2", 32'(stall),   32'd1);
    @(negedge clk); bus_gnt = 1'b0;
    #1 chk("lw.wait1_req",   32'(bus_req), 32'd0);
    chk("lw.wait1_stall", 32'(stall),   32'd1);
    @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1 chk("lw.wait2_stall", 32'(stall), 32'd1);
    @(negedge clk); bus_rvalid = 1'b0; bus_rdata = '0;
    #1 chk("lw.rdata",  rdata,              32'hDEAD_BEEF);
    chk("lw.valid",  32'(rdata_valid), 32'd1);
    chk("lw.stall",  32'(stall),       32'd0);
    @(negedge clk);
    #1 chk("lw.idle_valid", 32'(rdata_valid), 32'd0);
    chk("lw.idle_hold",  rdata,              32'hDEAD_BEEF);

    // Sub-word loads
    do_load("lb",  3'b000, 32'h103, 32'h80FF_1234, 4'b1000, 32'h100, 32'hFFFF_FF80);
    do_load("lbu", 3'b011, 32'h103, 32'h80FF_1234, 4'b1000, 32'h100, 32'h0000_0080);
    do_load("lhu", 3'b100, 32'h102, 32'h80FF_1234, 4'b1100, 32'h100, 32'h0000_80FF);
    do_load("lh",  3'b001, 32'h102, 32'h80FF_1234, 4'b1100, 32'h100, 32'hFFFF_80FF);
    do_load("lh0", 3'b001, 32'h200, 32'h1234_8001, 4'b0011, 32'h200, 32'hFFFF_8001);
    do_load("lb1", 3'b000, 32'h301, 32'h1234_7F55, 4'b0010, 32'h300, 32'h0000_007F);

    // SH 0x202: three cycles without grant, lanes must hold steady
    @(negedge clk); mem_wr = 1'b1; mem_ctrl = 3'b110; addr = 32'h202; wdata = 32'h1234_ABCD;
    #1 chk("sh.start_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_wr = 1'b0; wdata = 32'hFFFF_FFFF; addr = 32'h0; bus_gnt = (i == 3);
      #1 chk($sformatf("sh.req%0d", i),   32'(bus_req), 32'd1);
      chk($sformatf("sh.we%0d", i),    32'(bus_we),  32'd1);
      chk($sformatf("sh.be%0d", i),    32'(bus_be),  32'hC);
      chk($sformatf("sh.wd%0d", i),    bus_wdata,    32'hABCD_ABCD);
      chk($sformatf("sh.addr%0d", i),  bus_addr,     32'h200);
      chk($sformatf("sh.stall%0d", i), 32'(stall),   32'd1);
    end
    // DONE must ignore a new (even misaligned) request
    @(negedge clk); bus_gnt = 1'b0; mem_rd = 1'b1; mem_ctrl = 3'b010; addr = 32'h101;
    #1 chk_quiet("sh.done");
    chk("sh.done_valid", 32'(rdata_valid), 32'd0);
    @(negedge clk); mem_rd = 1'b0;
    #1 chk_quiet("sh.after");

    // Misaligned LW, misaligned LH, and illegal encodings in both directions
    @(negedge clk); mem_rd = 1'b1; mem_ctrl = 3'b010; addr = 32'h101;
    #1 chk("mis_lw.fault", 32'(fault),       32'd1);
    chk("mis_lw.cause", 32'(fault_cause), 32'd1);
    chk("mis_lw.stall", 32'(stall),       32'd0);
    chk("mis_lw.req",   32'(bus_req),     32'd0);
    @(negedge clk); mem_ctrl = 3'b001; addr = 32'h103;
    #1 chk("mis_lh.cause", 32'(fault_cause), 32'd1);
    chk("mis_lh.req",   32'(bus_req),     32'd0);
    @(negedge clk); mem_rd = 1'b0; mem_wr = 1'b1; mem_ctrl = 3'b010; addr = 32'h100;
    #1 chk("enc_st.fault", 32'(fault),       32'd1);
    chk("enc_st.cause", 32'(fault_cause), 32'd2);
    chk("enc_st.stall", 32'(stall),       32'd0);
    @(negedge clk); mem_wr = 1'b0; mem_rd = 1'b1; mem_ctrl = 3'b101;
    #1 chk("enc_ld.cause", 32'(fault_cause), 32'd2);
    // Both high: store wins, so ctrl=LW is an encoding fault
    @(negedge clk); mem_wr = 1'b1; mem_ctrl = 3'b010; addr = 32'h101;
    #1 chk("prio.cause", 32'(fault_cause), 32'd2);
    @(negedge clk); mem_wr = 1'b0; mem_rd = 1'b0;
    #1 chk_quiet("fault.after");
    chk("fault.cause0", 32'(fault_cause), 32'd0);

    // Timeout: grant never arrives
    @(negedge clk); mem_rd = 1'b1; mem_ctrl = 3'b010; addr = 32'h300;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); mem_rd = 1'b0;
      #1 chk($sformatf("to.req%0d", i), 32'(bus_req), 32'd1);
    end
    @(negedge clk);
    #1 chk("to.fault", 32'(fault),       32'd1);
    chk("to.cause", 32'(fault_cause), 32'd3);
    chk("to.valid", 32'(rdata_valid), 32'd0);
    chk("to.rdata", rdata,            32'd0);
    chk("to.stall", 32'(stall),       32'd0);
    chk("to.req",   32'(bus_req),     32'd0);
    @(negedge clk);
    #1 chk_quiet("to.idle");

    // Reset while waiting for read data
    @(negedge clk); mem_rd = 1'b1; mem_ctrl = 3'b010; addr = 32'h400;
    @(negedge clk); mem_rd = 1'b0; bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0;
    #1 chk("rw.stall_pre", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1 chk_quiet("rw.rst");
    chk("rw.valid", 32'(rdata_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // SW after reset, then a late read response in IDLE
    @(negedge clk); mem_wr = 1'b1; mem_ctrl = 3'b111; addr = 32'h404; wdata = 32'hCAFE_F00D;
    @(negedge clk); mem_wr = 1'b0; bus_gnt = 1'b1;
    #1 chk("sw.req",  32'(bus_req), 32'd1);
    chk("sw.be",   32'(bus_be),  32'hF);
    chk("sw.wd",   bus_wdata,    32'hCAFE_F00D);
    chk("sw.addr", bus_addr,     32'h404);
    @(negedge clk); bus_gnt = 1'b0;
    #1 chk("sw.done_stall", 32'(stall), 32'd0);
    chk("sw.done_valid", 32'(rdata_valid), 32'd0);
    @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk); bus_rvalid = 1'b0;
    #1 chk("late.valid", 32'(rdata_valid), 32'd0);
    chk("late.rdata", rdata,            32'd0);
    chk_quiet("late");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
